// File: rtl/handshake_master.sv
// Valid/ready transmit master: producer bytes are queued in a small FIFO and presented one at a time
// on registered valid/data_out. Optional stall watchdog is enabled with `define HS_MASTER_STALL_TIMEOUT_EN.
module handshake_master #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              busy,
    output logic              stall_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  xfer_cnt_q;
    logic              empty;
    logic              full;
    logic              push_fire;
    logic              xfer;

    // Parameter sanity: DEPTH must be a power of two >= 2, TIMEOUT at least 1.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    end

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ready = !full;
    assign push_fire  = push_valid && !full;
    assign xfer       = valid_q && ready_in;

    assign valid      = valid_q;
    assign data_out   = data_q;
    assign xfer_count = xfer_cnt_q;
    assign busy       = !empty || valid_q;

    always_ff @(posedge clk) begin
        if (push_fire && !rst) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            data_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            xfer_cnt_q <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (xfer) begin
                xfer_cnt_q <= xfer_cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        data_q   <= mem[rd_ptr_q[AW-1:0]];
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    // The pop only sees entries written on earlier edges; no same-cycle bypass.
                    if (ready_in) begin
                        if (!empty) begin
                            data_q   <= mem[rd_ptr_q[AW-1:0]];
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef HS_MASTER_STALL_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall_cnt_q;
    logic          stall_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else if (valid_q && !ready_in) begin
            if (stall_cnt_q != SW'(TIMEOUT)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            // Flag on the edge the counter reaches TIMEOUT; sticky until reset.
            if (stall_cnt_q >= SW'(TIMEOUT - 1)) begin
                stall_err_q <= 1'b1;
            end
        end else begin
            stall_cnt_q <= '0;
        end
    end

    assign stall_err = stall_err_q;
`else
    assign stall_err = 1'b0;
`endif

endmodule

// File: doc/handshake_master.md
Name: handshake_master

Overview:
- Transmitting end of the team's 8-bit valid/ready handshake; drives `valid` and `data_out` toward the handshake slave and consumes its `ready`.
- A local producer pushes bytes into an internal FIFO.
- The block presents FIFO entries one at a time on a registered output stage, obeying the handshake rules.
- Sits between a data source and any slave-side block on the same link.

Parameters:
- DATA_W, 8, width of pushed and transmitted data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the transfer counter.
- TIMEOUT, 255, stall cycles before `stall_err` sets (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- push_valid  input  1  producer offers `push_data`.
- push_data  input  DATA_W  producer byte.
- push_ready  output  1  FIFO can accept; equals !full.
- valid  output  1  `data_out` holds a transfer.
- data_out  output  DATA_W  byte offered to the slave.
- ready_in  input  1  slave ready.
- xfer_count  output  CNT_W  completed transfers since reset.
- busy  output  1  FIFO non-empty or `valid` high.
- stall_err  output  1  sticky stall-timeout flag.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high. All state changes only on the rising edge of `clk`.
- Reset values:
  - `valid` = 0, `data_out` = 0, `xfer_count` = 0, `stall_err` = 0.
  - FIFO empty, so `push_ready` = 1 and `busy` = 0.
- Push side:
  - Entry written when `push_valid` && `push_ready` at an edge.
  - `push_ready` is combinational from FIFO occupancy only.
  - FIFO full (DEPTH entries): `push_ready` = 0, even if a pop occurs that same cycle. There is no bypass.
- FIFO storage:
  - Read and write pointers are log2(DEPTH)+1 bits wide.
  - Full: MSBs differ and the rest are equal.
  - Empty: the pointers are equal.
  - Pointers wrap naturally.
- Handshake transfer: occurs at an edge where `valid` && `ready_in`.
- Output rules:
  - `valid` and `data_out` are registered.
  - `valid` never depends combinationally on `ready_in`.
  - Once `valid` = 1, `valid` and `data_out` stay stable until the transfer edge.
- State machine:
  - IDLE (`valid` = 0):
    - FIFO non-empty at an edge: pop head into `data_out`, set `valid`, go to SEND.
  - SEND (`valid` = 1):
    - No transfer: hold.
    - Transfer and FIFO non-empty: pop next head into `data_out` the same edge, stay in SEND. This gives back-to-back transfers, one per cycle.
    - Transfer and FIFO empty: clear `valid`, go to IDLE. `data_out` keeps its last value.
- Latency:
  - A push accepted at edge E0 into an empty FIFO while IDLE gives `valid` = 1 after edge E1.
  - Throughput is 1 byte per cycle when `ready_in` is held high.
  - A push to an empty FIFO while SEND is completing joins normally. The pop sees the entry only after its write edge.
- Simultaneous push and pop with the FIFO neither full nor empty: occupancy unchanged.
- Counter and busy:
  - `xfer_count` increments by 1 per transfer and wraps from all-ones to 0.
  - `busy` = !empty || `valid`.
- Reset mid-operation:
  - FIFO is flushed, `valid` drops at that edge, and all counters clear.
  - In-flight data is discarded.
  - Inputs are ignored during reset.

Optional Feature:
- Macro: HS_MASTER_STALL_TIMEOUT_EN.
- Defined:
  - A stall counter increments each cycle `valid` && !`ready_in`.
  - It clears on a transfer or when `valid` = 0, and saturates at TIMEOUT.
  - When it reaches TIMEOUT, `stall_err` sets and stays set until `rst`.
  - The transfer is not aborted; `valid` and `data_out` remain held.
- Undefined: no counter logic; `stall_err` tied to 0.

Test Plan:
- Reset check: `rst` high for 2 cycles -> `valid` = 0, `data_out` = 0x00, `push_ready` = 1, `xfer_count` = 0, `busy` = 0.
- Single transfer: push 0xA5 at E0 with `ready_in` = 1 -> `valid` = 1 / `data_out` = 0xA5 after E1; transfer at E2; `valid` = 0 after E2; `xfer_count` = 1.
- Back-pressure: push 0x11, 0x22, 0x33, 0x44 with `ready_in` = 0 -> `valid` = 1 with `data_out` = 0x11 held stable.
  - Remaining pushes fill 3 of the 4 FIFO entries; the 5th push is accepted and makes the FIFO full.
  - `push_ready` = 0 at full.
  - Raise `ready_in` -> 0x11, 0x22, 0x33, 0x44, then the 5th byte, one per cycle; `xfer_count` = 5.
- Streaming: push 0x00..0x0F continuously with `ready_in` = 1 -> 16 consecutive transfers in order, no `valid` gaps after the first.
- Reset mid-burst: `rst` asserted with 3 entries queued and `valid` = 1 -> `valid` = 0 and `busy` = 0 next edge; after release, no stale byte is ever sent.
- With HS_MASTER_STALL_TIMEOUT_EN and TIMEOUT = 8: hold `ready_in` = 0 for 10 cycles with `valid` = 1 -> `stall_err` = 1 after the 8th stall edge and stays 1 after a later transfer, until `rst`.
